spu_pipe_delay_line: RTL



---
 rtl/spu_pipe_pkg.sv | 18 +
 rtl/spu_pipe_slot.sv | 57 +++++
 rtl/spu_pipe_delay_line.sv | 132 +++++++++++++
 3 files changed

// File: rtl/spu_pipe_pkg.sv
// spu_pipe_pkg
//   Shared types and default widths for the SPU execute-side delay line.
//   pipe_entry_t is the contents of one pipeline stage at default widths.
package spu_pipe_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int PC_W_DEF   = 11;
    localparam int REG_W_DEF  = 7;

    typedef struct packed {
        logic                  valid;
        logic                  wr_en;
        logic [REG_W_DEF-1:0]  rt;
        logic [DATA_W_DEF-1:0] data;
        logic [PC_W_DEF-1:0]   pc;
    } pipe_entry_t;

endpackage

// File: rtl/spu_pipe_slot.sv
// spu_pipe_slot
//   One stage of the SPU delay line: a register holding {valid, wr_en, rt,
//   data, pc}.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   load                1: take ld_* this edge; 0: hold current contents
//   kill                clear valid and wr_en after the load/hold choice
//   ld_*                candidate contents (previous stage or pipe input)
//   valid, wr_en, rt,
//   data, pc            current contents of this stage
module spu_pipe_slot
    import spu_pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PC_W   = PC_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              kill,
    input  logic              ld_valid,
    input  logic              ld_wr_en,
    input  logic [REG_W-1:0]  ld_rt,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [PC_W-1:0]   ld_pc,
    output logic              valid,
    output logic              wr_en,
    output logic [REG_W-1:0]  rt,
    output logic [DATA_W-1:0] data,
    output logic [PC_W-1:0]   pc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            wr_en <= 1'b0;
            rt    <= '0;
            data  <= '0;
            pc    <= '0;
        end else begin
            if (load) begin
                valid <= ld_valid;
                wr_en <= ld_wr_en;
                rt    <= ld_rt;
                data  <= ld_data;
                pc    <= ld_pc;
            end
            // Kill overrides whatever load/hold chose; payload left stale.
            if (kill) begin
                valid <= 1'b0;
                wr_en <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/spu_pipe_delay_line.sv
// spu_pipe_delay_line
//   DEPTH-stage stallable, flushable instruction/result pipeline with a
//   built-in forwarding lookup. Stage 0 is the youngest; out_* is stage
//   DEPTH-1 and feeds writeback.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   stall               hold all stages, ignore in_*
//   flush_mask[i]       kill the entry that would occupy stage i after the edge
//   in_*                instruction presented to stage 0
//   out_*               contents of the last stage (qualify with out_valid)
//   stage_valid         per-stage valid bits for hazard logic
//   query_rt            source register to look up
//   fwd_hit/fwd_data    youngest match is final; its data (0 otherwise)
//   fwd_pending         youngest match is not yet final; issue must stall
module spu_pipe_delay_line
    import spu_pipe_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int PC_W         = PC_W_DEF,
    parameter int REG_W        = REG_W_DEF,
    parameter int DEPTH        = 7,
    parameter int RESULT_STAGE = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [DEPTH-1:0]  flush_mask,
    input  logic              in_valid,
    input  logic              in_wr_en,
    input  logic [REG_W-1:0]  in_rt,
    input  logic [DATA_W-1:0] in_data,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    output logic              out_wr_en,
    output logic [REG_W-1:0]  out_rt,
    output logic [DATA_W-1:0] out_data,
    output logic [PC_W-1:0]   out_pc,
    output logic [DEPTH-1:0]  stage_valid,
    input  logic [REG_W-1:0]  query_rt,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
    output logic              fwd_pending
);

    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $error("spu_pipe_delay_line: DEPTH must be in 1..8");
    end
    if (RESULT_STAGE < 0 || RESULT_STAGE >= DEPTH) begin : g_bad_result_stage
        $error("spu_pipe_delay_line: RESULT_STAGE must be in 0..DEPTH-1");
    end

    logic [DEPTH-1:0]  st_valid;
    logic [DEPTH-1:0]  st_wr_en;
    logic [REG_W-1:0]  st_rt   [DEPTH];
    logic [DATA_W-1:0] st_data [DEPTH];
    logic [PC_W-1:0]   st_pc   [DEPTH];

    logic [DEPTH-1:0]  ld_valid;
    logic [DEPTH-1:0]  ld_wr_en;
    logic [REG_W-1:0]  ld_rt   [DEPTH];
    logic [DATA_W-1:0] ld_data [DEPTH];
    logic [PC_W-1:0]   ld_pc   [DEPTH];

    logic [DEPTH-1:0]  match;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign ld_valid[i] = in_valid;
            assign ld_wr_en[i] = in_wr_en;
            assign ld_rt[i]    = in_rt;
            assign ld_data[i]  = in_data;
            assign ld_pc[i]    = in_pc;
        end else begin : g_body
            assign ld_valid[i] = st_valid[i-1];
            assign ld_wr_en[i] = st_wr_en[i-1];
            assign ld_rt[i]    = st_rt[i-1];
            assign ld_data[i]  = st_data[i-1];
            assign ld_pc[i]    = st_pc[i-1];
        end

        spu_pipe_slot #(
            .DATA_W (DATA_W),
            .PC_W   (PC_W),
            .REG_W  (REG_W)
        ) u_slot (
            .clk      (clk),
            .reset    (reset),
            .load     (~stall),
            .kill     (flush_mask[i]),
            .ld_valid (ld_valid[i]),
            .ld_wr_en (ld_wr_en[i]),
            .ld_rt    (ld_rt[i]),
            .ld_data  (ld_data[i]),
            .ld_pc    (ld_pc[i]),
            .valid    (st_valid[i]),
            .wr_en    (st_wr_en[i]),
            .rt       (st_rt[i]),
            .data     (st_data[i]),
            .pc       (st_pc[i])
        );

        assign match[i] = st_valid[i] & st_wr_en[i] & (st_rt[i] == query_rt);
    end

    assign out_valid   = st_valid[DEPTH-1];
    assign out_wr_en   = st_wr_en[DEPTH-1];
    assign out_rt      = st_rt[DEPTH-1];
    assign out_data    = st_data[DEPTH-1];
    assign out_pc      = st_pc[DEPTH-1];
    assign stage_valid = st_valid;

    // Youngest (lowest-index) match wins; older matches are shadowed by it.
    always_comb begin
        logic found;
        found       = 1'b0;
        fwd_hit     = 1'b0;
        fwd_pending = 1'b0;
        fwd_data    = '0;
        for (int unsigned i = 0; i < int'(DEPTH); i++) begin
            if (!found && match[i]) begin
                found = 1'b1;
                if (i >= int'(RESULT_STAGE)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = st_data[i];
                end else begin
                    fwd_pending = 1'b1;
                end
            end
        end
    end

endmodule
